// File: rtl/cronometro_pkg.sv
// cronometro_pkg: shared types and 7-segment constants for the stopwatch digit stages
package cronometro_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    // Segment patterns {a,b,c,d,e,f,g}, entry n is digit n
    localparam logic [9:0][6:0] SEG_LUT = {
        7'b1111011,
        7'b1111111,
        7'b1110000,
        7'b1011111,
        7'b1011011,
        7'b0110011,
        7'b1111001,
        7'b1101101,
        7'b0110000,
        7'b1111110
    };

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_ERR   = 7'b0000001;

endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: BCD digit to active-high 7-segment pattern, non-decimal codes show a lone g segment
module seg7_dec
    import cronometro_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output logic [6:0]         seg
);

    // Pure table lookup so the digit display tracks the register with no delay
    always_comb begin
        seg = (bcd <= DIGIT_W'(9)) ? SEG_LUT[bcd] : SEG_ERR;
    end

endmodule

// File: rtl/unidade_min.sv
// unidade_min: units-of-minutes digit with start/pause/clear/preset control; optional blink via UNID_MIN_BLINK_EN
module unidade_min
    import cronometro_pkg::*;
#(
    parameter int MAX_DIGIT = 9
`ifdef UNID_MIN_BLINK_EN
    ,
    parameter int BLINK_HALF = 25000000
`endif
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               tick,
    input  logic               btn_sp,
    input  logic               btn_clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] bcd,
    output logic               co,
    output logic               running,
    output logic [6:0]         seg
);

    localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX_DIGIT);

    state_t             state, state_n;
    logic [DIGIT_W-1:0] bcd_n;
    logic               co_n;
    logic               sp_prev;
    logic               sp_edge;
    logic [6:0]         digit_seg;

    assign sp_edge = btn_sp & ~sp_prev;

    // Next state and digit: clear beats preset, preset beats counting and start/pause
    always_comb begin
        state_n = state;
        bcd_n   = bcd;
        co_n    = 1'b0;
        if (btn_clr) begin
            state_n = IDLE;
            bcd_n   = '0;
        end else if (load && state != RUN) begin
            bcd_n = (load_val > MAX_D) ? MAX_D : load_val;
        end else if (state == RUN) begin
            if (tick) begin
                bcd_n = (bcd == MAX_D) ? '0 : bcd + 1'b1;
                co_n  = (bcd == MAX_D);
            end
            if (sp_edge)
                state_n = PAUSED;
        end else if (sp_edge) begin
            state_n = RUN;
        end
    end

    // Registered state, digit, carry and run flag; button history updates every cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            bcd     <= '0;
            co      <= 1'b0;
            running <= 1'b0;
            sp_prev <= 1'b0;
        end else begin
            state   <= state_n;
            bcd     <= bcd_n;
            co      <= co_n;
            running <= (state_n == RUN);
            sp_prev <= btn_sp;
        end
    end

    seg7_dec u_dec (
        .bcd (bcd),
        .seg (digit_seg)
    );

`ifdef UNID_MIN_BLINK_EN
    localparam int BW = $clog2(BLINK_HALF + 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_off;

    // Half-period timer runs only while paused and restarts with the display lit
    always_ff @(posedge CLK) begin
        if (RST || btn_clr || state != PAUSED) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign seg = (state == PAUSED && blink_off) ? SEG_BLANK : digit_seg;
`else
    assign seg = digit_seg;
`endif

endmodule

// File: tb/tb_unidade_min.sv
// tb_unidade_min: directed vector table plus a blink/steady display sequence for unidade_min
module tb_unidade_min;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       tick = 1'b0;
    logic       btn_sp = 1'b0;
    logic       btn_clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] bcd;
    logic       co;
    logic       running;
    logic [6:0] seg;

    int nchk = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    unidade_min #(
        .MAX_DIGIT (9)
`ifdef UNID_MIN_BLINK_EN
        ,
        .BLINK_HALF (4)
`endif
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .tick     (tick),
        .btn_sp   (btn_sp),
        .btn_clr  (btn_clr),
        .load     (load),
        .load_val (load_val),
        .bcd      (bcd),
        .co       (co),
        .running  (running),
        .seg      (seg)
    );

    typedef struct {
        logic       rst, sp, clr, ld;
        logic [3:0] lv;
        logic       tk;
        logic [3:0] bcd;
        logic       co;
        int         st;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic rst, sp, clr, ld, input logic [3:0] lv,
                                input logic tk, input logic [3:0] b, input logic c, input int st);
        vec_t v;
        v.rst = rst; v.sp = sp; v.clr = clr; v.ld = ld; v.lv = lv; v.tk = tk;
        v.bcd = b; v.co = c; v.st = st;
        vq.push_back(v);
    endfunction

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000001;
        endcase
    endfunction

    task automatic chk(input string name, input int idx, input logic [6:0] act, input logic [6:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, sp, clr, ld, input logic [3:0] lv, input logic tk);
        @(negedge CLK);
        RST = rst; btn_sp = sp; btn_clr = clr; load = ld; load_val = lv; tick = tk;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // reset, start, full count with wrap
        add(1,0,0,0,0,0, 0,0,0);
        add(0,1,0,0,0,0, 0,0,1);
        for (int i = 1; i <= 10; i++) add(0,0,0,0,0,1, 4'(i % 10), i == 10, 1);
        add(0,0,0,0,0,0, 0,0,1);
        for (int i = 1; i <= 4; i++) add(0,0,0,0,0,1, 4'(i), 0, 1);
        // pause together with tick, then ticks ignored
        add(0,1,0,0,0,1, 5,0,2);
        for (int i = 0; i < 3; i++) add(0,0,0,0,0,1, 5,0,2);
        // preset while paused, saturation, preset ignored in RUN
        add(0,0,0,1,7,0, 7,0,2);
        add(0,0,0,1,12,0, 9,0,2);
        add(0,0,0,1,3,0, 3,0,2);
        add(0,1,0,0,0,0, 3,0,1);
        add(0,0,0,1,8,0, 3,0,1);
        add(0,0,0,1,0,1, 4,0,1);
        for (int i = 5; i <= 9; i++) add(0,0,0,0,0,1, 4'(i), 0, 1);
        // clear beats tick at 9, tick in IDLE ignored
        add(0,0,1,0,0,1, 0,0,0);
        add(0,0,0,0,0,1, 0,0,0);
        // held button gives a single edge
        for (int i = 0; i < 20; i++) add(0,1,0,0,0,0, 0,0,1);
        add(0,0,0,0,0,0, 0,0,1);
        add(0,1,0,0,0,0, 0,0,2);
        add(0,0,0,0,0,0, 0,0,2);
        add(0,1,0,0,0,0, 0,0,1);
        add(0,0,0,0,0,0, 0,0,1);
        add(0,1,0,0,0,0, 0,0,2);
        add(0,0,0,0,0,0, 0,0,2);
        // preset beats start edge in PAUSED
        add(0,1,0,1,2,0, 2,0,2);
        add(0,0,0,0,0,0, 2,0,2);
        // clear beats edge, held clear masks everything
        add(0,1,1,0,0,1, 0,0,0);
        add(0,1,1,1,5,1, 0,0,0);
        add(0,0,0,0,0,0, 0,0,0);
        add(0,1,0,0,0,0, 0,0,1);
        add(0,0,0,0,0,1, 1,0,1);
        add(1,0,0,0,0,1, 0,0,0);
        // preset in IDLE, saturation from 15, wrap right after preset
        add(0,0,0,1,9,0, 9,0,0);
        add(0,0,0,1,15,0, 9,0,0);
        add(0,0,0,0,0,1, 9,0,0);
        add(0,1,0,0,0,0, 9,0,1);
        add(0,0,0,0,0,1, 0,1,1);
        add(0,0,0,0,0,0, 0,0,1);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].sp, vq[i].clr, vq[i].ld, vq[i].lv, vq[i].tk);
            chk("bcd", i, 7'(bcd), 7'(vq[i].bcd));
            chk("co", i, 7'(co), 7'(vq[i].co));
            chk("running", i, 7'(running), 7'(vq[i].st == 1));
`ifdef UNID_MIN_BLINK_EN
            if (vq[i].st != 2) chk("seg", i, seg, ref_seg(vq[i].bcd));
`else
            chk("seg", i, seg, ref_seg(vq[i].bcd));
`endif
        end

        // pause at 3: blinks with the feature, steady without; then steady after resume
        drive(1,0,0,0,0,0);
        drive(0,0,0,1,3,0);
        drive(0,1,0,0,0,0);
        drive(0,0,0,0,0,0);
        drive(0,1,0,0,0,0);
        chk("pause_run", 0, 7'(running), 7'(0));
        for (int i = 0; i < 12; i++) begin
`ifdef UNID_MIN_BLINK_EN
            chk("blink_seg", i, seg, ((i / 4) % 2) ? 7'b0000000 : 7'b1111001);
`else
            chk("paused_seg", i, seg, 7'b1111001);
`endif
            drive(0,0,0,0,0,0);
        end
        drive(0,1,0,0,0,0);
        for (int i = 0; i < 8; i++) begin
            chk("resume_seg", i, seg, 7'b1111001);
            drive(0,0,0,0,0,0);
        end
        chk("resume_run", 0, 7'(running), 7'(1));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
